// File: rtl/reg_file.sv
// rtl/reg_file.sv - eight-entry register file, one write port, two combinational read ports
module reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8,
    parameter int ADDR_WIDTH = 3,
    parameter bit BYPASS     = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2
);

    // Register storage; r0 is an ordinary register, not a hardwired zero.
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    // Stored values seen by each read port before any forwarding.
    logic [DATA_WIDTH-1:0] stored1;
    logic [DATA_WIDTH-1:0] stored2;

    // Write-back: asynchronous clear, otherwise one register updated per enabled edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
        end
    end

    // Combinational read of stored data for both ports.
    always_comb begin
        stored1 = regs[OUT1ADDRESS];
        stored2 = regs[OUT2ADDRESS];
    end

    generate
        if (BYPASS) begin : g_bypass
            // Same-cycle forwarding of the write data; only legal when IN does not
            // depend on OUT1/OUT2, otherwise it closes a loop through the ALU.
            always_comb begin
                OUT1 = (WRITE && (OUT1ADDRESS == INADDRESS)) ? IN : stored1;
                OUT2 = (WRITE && (OUT2ADDRESS == INADDRESS)) ? IN : stored2;
            end
        end else begin : g_no_bypass
            // Reads see the old value until the write edge has happened.
            always_comb begin
                OUT1 = stored1;
                OUT2 = stored2;
            end
        end
    endgenerate

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - directed self-checking bench for reg_file
`timescale 1ns/1ps
module tb_reg_file;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;
    logic [7:0] OUT1_b;
    logic [7:0] OUT2_b;

    int total = 0;
    int bad   = 0;

    reg_file #(.DATA_WIDTH(8), .REG_COUNT(8), .ADDR_WIDTH(3), .BYPASS(1'b0)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1), .OUT2(OUT2)
    );

    reg_file #(.DATA_WIDTH(8), .REG_COUNT(8), .ADDR_WIDTH(3), .BYPASS(1'b1)) dut_byp (
        .CLK(CLK), .RESET_N(RESET_N), .IN(IN), .INADDRESS(INADDRESS), .WRITE(WRITE),
        .OUT1ADDRESS(OUT1ADDRESS), .OUT2ADDRESS(OUT2ADDRESS), .OUT1(OUT1_b), .OUT2(OUT2_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%02h exp=%02h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [2:0] a, input logic [7:0] d);
        IN        = d;
        INADDRESS = a;
        WRITE     = 1'b1;
        @(posedge CLK);
        #1;
        WRITE     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
        OUT1ADDRESS = a1;
        OUT2ADDRESS = a2;
        #1;
    endtask

    initial begin
        RESET_N     = 1'b0;
        IN          = 8'h00;
        INADDRESS   = 3'd0;
        WRITE       = 1'b0;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd7;
        #1;
        check("reset_out1", OUT1, 8'h00);
        check("reset_out2", OUT2, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Write r3 then clear it with a reset pulse that spans no edge
        do_write(3'd3, 8'hA5);
        rd(3'd3, 3'd3);
        check("r3_written", OUT1, 8'hA5);
        RESET_N = 1'b0;
        #1;
        check("r3_async_clear", OUT1, 8'h00);
        for (int i = 0; i < 8; i += 2) begin
            rd(i[2:0], 3'(i + 1));
            check($sformatf("reset_all_r%0d", i), OUT1, 8'h00);
            check($sformatf("reset_all_r%0d", i + 1), OUT2, 8'h00);
        end
        @(negedge CLK);
        RESET_N = 1'b1;

        // Consecutive writes, dual reads, OR of operands
        do_write(3'd1, 8'h0F);
        do_write(3'd2, 8'hF0);
        rd(3'd1, 3'd2);
        check("r1_read", OUT1, 8'h0F);
        check("r2_read", OUT2, 8'hF0);
        check("alu_or", OUT1 | OUT2, 8'hFF);

        // Write enable gating over three edges
        IN        = 8'h55;
        INADDRESS = 3'd4;
        WRITE     = 1'b0;
        rd(3'd4, 3'd4);
        repeat (3) @(posedge CLK);
        #1;
        check("r4_gated", OUT1, 8'h00);
        do_write(3'd4, 8'h55);
        check("r4_enabled", OUT1, 8'h55);

        // Read-during-write, with and without forwarding
        do_write(3'd6, 8'h11);
        rd(3'd6, 3'd0);
        IN        = 8'h22;
        INADDRESS = 3'd6;
        WRITE     = 1'b1;
        #1;
        check("rdw_before", OUT1, 8'h11);
        check("rdw_bypass", OUT1_b, 8'h22);
        check("rdw_nobyp_other", OUT2_b, 8'h00);
        @(posedge CLK);
        #1;
        WRITE = 1'b0;
        check("rdw_after", OUT1, 8'h22);

        // Both ports on the same register
        do_write(3'd7, 8'h80);
        rd(3'd7, 3'd7);
        check("same_addr_p1", OUT1, 8'h80);
        check("same_addr_p2", OUT2, 8'h80);

        // Walk every register; the neighbour below must keep its new value
        for (int i = 0; i < 8; i++) begin
            do_write(i[2:0], 8'h10 + 8'(i));
            rd(i[2:0], 3'(i + 7));
            check($sformatf("walk_r%0d", i), OUT1, 8'h10 + 8'(i));
            if (i > 0) check($sformatf("walk_nb_r%0d", i - 1), OUT2, 8'h10 + 8'(i - 1));
        end
        for (int i = 0; i < 8; i++) begin
            rd(i[2:0], 3'(7 - i));
            check($sformatf("walk_all_p1_r%0d", i), OUT1, 8'h10 + 8'(i));
            check($sformatf("walk_all_p2_r%0d", 7 - i), OUT2, 8'h10 + 8'(7 - i));
        end

        // Back-to-back writes to one address keep the last value
        do_write(3'd5, 8'hAA);
        do_write(3'd5, 8'hBB);
        rd(3'd5, 3'd4);
        check("b2b_last", OUT1, 8'hBB);
        check("b2b_neighbour", OUT2, 8'h14);

        // Reset pulse mid-cycle with a write pending at the next edge
        do_write(3'd0, 8'h40);
        do_write(3'd1, 8'h41);
        do_write(3'd2, 8'h42);
        do_write(3'd3, 8'h43);
        OUT1ADDRESS = 3'd3;
        OUT2ADDRESS = 3'd2;
        IN          = 8'h99;
        INADDRESS   = 3'd2;
        WRITE       = 1'b1;
        #1;
        check("mid_pre_r3", OUT1, 8'h43);
        RESET_N = 1'b0;
        #1;
        check("mid_clear_r2", OUT2, 8'h00);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        WRITE = 1'b0;
        rd(3'd2, 3'd0);
        check("mid_r2_pending", OUT1, 8'h99);
        check("mid_r0", OUT2, 8'h00);
        rd(3'd1, 3'd3);
        check("mid_r1", OUT1, 8'h00);
        check("mid_r3", OUT2, 8'h00);

        // Write edge during held reset is ignored
        @(negedge CLK);
        RESET_N   = 1'b0;
        IN        = 8'h77;
        INADDRESS = 3'd5;
        WRITE     = 1'b1;
        OUT1ADDRESS = 3'd5;
        @(posedge CLK);
        #1;
        WRITE = 1'b0;
        check("held_reset_write", OUT1, 8'h00);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("held_reset_release", OUT1, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Eight-entry, 8-bit general-purpose register file for the single-cycle processor. It sits directly upstream of the ALU. Read port 1 drives ALU `DATA1` and read port 2 drives the operand path to `DATA2`. The write port takes ALU `RESULT` back in at the end of each instruction cycle. Storage is edge-triggered and reads are combinational, so one instruction completes per clock: read, compute, then write back on the next rising edge.

## Interface
- `DATA_WIDTH`, 8: bits per register; matches the ALU operand width.
- `REG_COUNT`, 8: number of registers; must be a power of two.
- `ADDR_WIDTH`, 3: register address width; must equal log2(`REG_COUNT`).
- `BYPASS`, 0: when 1, a read of the address being written returns `IN` in the same cycle. Must stay 0 in the single-cycle datapath, because OUT→ALU→IN would form a combinational loop.

- `CLK` input 1: single clock; all state updates on its rising edge.
- `RESET_N` input 1: asynchronous, active-low reset.
- `IN` input `DATA_WIDTH`: write data, normally the ALU `RESULT`.
- `INADDRESS` input `ADDR_WIDTH`: destination register.
- `WRITE` input 1: write enable, sampled on the rising edge of `CLK`.
- `OUT1ADDRESS` input `ADDR_WIDTH`: read port 1 address.
- `OUT2ADDRESS` input `ADDR_WIDTH`: read port 2 address.
- `OUT1` output `DATA_WIDTH`: read port 1 data, to ALU `DATA1`.
- `OUT2` output `DATA_WIDTH`: read port 2 data, to the `DATA2` operand path.

## Operation
- **Storage:** `REG_COUNT` registers r0..r7, each `DATA_WIDTH` bits wide. All registers are general purpose; r0 is not hardwired to zero.
- **Reset:** `RESET_N`=0 clears every register to 8'h00 immediately, with no dependence on `CLK`.
  - `OUT1` and `OUT2` therefore read 8'h00 during reset, whatever the addresses.
  - A write edge that arrives while `RESET_N`=0 is ignored.
- **Write:** on a rising `CLK` edge with `RESET_N`=1 and `WRITE`=1, register[`INADDRESS`] ← `IN`.
  - `WRITE`=0 leaves all registers unchanged.
  - Exactly one register is written per edge; no other register changes.
- **Read:** `OUT1` = register[`OUT1ADDRESS`] and `OUT2` = register[`OUT2ADDRESS`], both purely combinational.
  - The two ports are independent; both may address the same register.
- **Bypass (`BYPASS`=1 only):** if `WRITE`=1 and `OUTnADDRESS`==`INADDRESS`, then `OUTn`=`IN` combinationally. Otherwise the port reads stored data.
- **No arithmetic:** the block does no arithmetic and no width conversion. `IN` is stored bit-exact and read back bit-exact.
- **Address range:** out-of-range addresses cannot occur because `ADDR_WIDTH`=log2(`REG_COUNT`), so every address maps to a register.

## Timing
- **Write latency:** 1 edge. Data written at edge k is visible on a matching read port immediately after edge k.
- **Read-during-write (`BYPASS`=0):**
  - Before the edge, the read returns the old value.
  - After the edge, it returns the new value.
  - There is no same-cycle forwarding.
- **Read latency:** 0 cycles; the outputs follow the address inputs combinationally.
- **Setup:** `IN`, `INADDRESS` and `WRITE` must be stable before the rising edge. In the single-cycle datapath `IN` is the ALU output derived from `OUT1`/`OUT2`, so it is combinationally settled within the cycle.
- **Reset assertion:** asynchronous. The registers clear within the same delta as `RESET_N` falling, and `OUT1`/`OUT2` follow.
- **Reset release:** the first write is accepted on the first rising edge after `RESET_N` goes high. Release coincident with an edge does not guarantee that edge's write.
- **Reset mid-operation:** a `RESET_N` pulse between two edges wipes all previously written data. Any write pending at the next edge still applies if `RESET_N`=1 at that edge.
- **Write-enable hold:** back-to-back writes to the same address on consecutive edges keep only the last value. Consecutive writes to different addresses each land.

## Test plan
- **Reset:** write 8'hA5 to r3, then pulse `RESET_N` low without a clock edge → `OUT1` with `OUT1ADDRESS`=3 reads 8'h00 immediately. All eight registers read 8'h00.
- **Write then read:** write r1=8'h0F and r2=8'hF0 on consecutive edges, then set `OUT1ADDRESS`=1 and `OUT2ADDRESS`=2 → `OUT1`=8'h0F, `OUT2`=8'hF0. Feed into the ALU with SELECT=3'b001 → RESULT=8'hFF.
- **Write enable gating:** `WRITE`=0, `IN`=8'h55, `INADDRESS`=4 over 3 edges → r4 stays 8'h00. Then `WRITE`=1 for one edge → r4=8'h55.
- **Read-during-write (`BYPASS`=0):** r6=8'h11, then drive `IN`=8'h22, `INADDRESS`=6, `WRITE`=1 with `OUT1ADDRESS`=6 → `OUT1`=8'h11 before the edge and 8'h22 after it. With `BYPASS`=1 → `OUT1`=8'h22 before the edge.
- **Dual-port same address and write isolation:** write r7=8'h80, then both read addresses=7 → `OUT1`=`OUT2`=8'h80. Walk r0..r7 with values 8'h10..8'h17 → each readback is exact and no neighbour register is corrupted.
- **Reset mid-sequence:** write r0..r3, assert `RESET_N` low mid-cycle, release it before the next edge while a write of r2=8'h99 is pending → after that edge r2=8'h99 and r0, r1, r3 read 8'h00.
